display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with dead-time blanking and frame-synchronous double buffer.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits 3..1).
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEADTIME    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_data,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [7:0]  anode,
    output logic [3:0]  digit_code,
    output logic        digit_blank,
    output logic        frame_done
);

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned DATA_W = 16;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [DATA_W-1:0]   active, active_d;
    logic [DATA_W-1:0]   pending, pending_d;
    logic                pending_full, pending_full_d;

    logic                cnt_wrap;
    logic                boundary;
    logic                load_fire;
    logic                suppress;
    logic [3:0]          nibble_d;
    logic [7:0]          anode_d;
    logic                digit_blank_d;

    // State, counters, buffers and all outputs registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BLANK;
            cnt          <= '0;
            idx          <= '0;
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            anode        <= 8'hFF;
            digit_code   <= 4'h0;
            digit_blank  <= 1'b1;
            load_ready   <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
            active       <= active_d;
            pending      <= pending_d;
            pending_full <= pending_full_d;
            anode        <= anode_d;
            digit_code   <= nibble_d;
            digit_blank  <= digit_blank_d;
            load_ready   <= !pending_full_d;
            frame_done   <= boundary;
        end
    end

    // Next-state and next-output logic; outputs derive from next-cycle values so they track the state edge.
    always_comb begin
        state_d        = state;
        cnt_d          = cnt + CNT_W'(1);
        idx_d          = idx;
        active_d       = active;
        pending_d      = pending;
        pending_full_d = pending_full;
        suppress       = 1'b0;
        nibble_d       = 4'h0;
        anode_d        = 8'hFF;
        digit_blank_d  = 1'b1;

        cnt_wrap  = (cnt == CNT_W'(REFRESH_DIV - 1));
        boundary  = cnt_wrap && (idx == IDX_W'(3));
        load_fire = load_valid && load_ready;

        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = idx + IDX_W'(1);
        end

        case (state)
            BLANK: if (cnt == CNT_W'(DEADTIME - 1)) state_d = DRIVE;
            DRIVE: if (cnt_wrap) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        // Pending swaps in only at a frame boundary; a load can only land when pending is empty.
        if (boundary && pending_full) begin
            active_d       = pending;
            pending_full_d = 1'b0;
        end
        if (load_fire) begin
            pending_d      = bcd_data;
            pending_full_d = 1'b1;
        end

        case (idx_d)
            2'd0:    nibble_d = active_d[3:0];
            2'd1:    nibble_d = active_d[7:4];
            2'd2:    nibble_d = active_d[11:8];
            default: nibble_d = active_d[15:12];
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd3:    suppress = (active_d[15:12] == 4'h0);
            2'd2:    suppress = (active_d[15:8] == 8'h00);
            2'd1:    suppress = (active_d[15:4] == 12'h000);
            default: suppress = 1'b0;
        endcase
`else
        suppress = 1'b0;
`endif

        if (state_d == DRIVE && !suppress) begin
            anode_d       = ~(8'(1) << idx_d);
            digit_blank_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a time-indexed reference model (REFRESH_DIV=8, DEADTIME=2).
module tb_display_scan_ctrl;

    localparam int unsigned RD    = 8;
    localparam int unsigned DT    = 2;
    localparam int unsigned FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_data;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  anode;
    logic [3:0]  digit_code;
    logic        digit_blank;
    logic        frame_done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: time since reset plus the two buffers.
    int unsigned t;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_full;

    display_scan_ctrl #(.REFRESH_DIV(RD), .DEADTIME(DT)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_data   (bcd_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .anode      (anode),
        .digit_code (digit_code),
        .digit_blank(digit_blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic check_outputs();
        int unsigned cnt_e;
        int unsigned idx_e;
        bit          drive;
        bit          hide;
        logic [15:0] shifted;
        logic [3:0]  code_e;
        cnt_e   = t % RD;
        idx_e   = (t / RD) % 4;
        drive   = (cnt_e >= DT);
        shifted = m_active >> (4 * idx_e);
        code_e  = shifted[3:0];
        hide    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        hide = (idx_e != 0) && (shifted == 16'h0);
`endif
        check("anode", 32'(anode), (drive && !hide) ? 32'(8'hFF & ~(8'h01 << idx_e)) : 32'hFF);
        check("digit_blank", 32'(digit_blank), (drive && !hide) ? 32'd0 : 32'd1);
        check("digit_code", 32'(digit_code), 32'(code_e));
        check("load_ready", 32'(load_ready), m_full ? 32'd0 : 32'd1);
        check("frame_done", 32'(frame_done), (t > 0 && (t % FRAME) == 0) ? 32'd1 : 32'd0);
    endtask

    // One clock: check outputs, apply inputs, advance the model across the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic r);
        bit acc;
        @(negedge clk);
        check_outputs();
        reset      = r;
        load_valid = v;
        bcd_data   = d;
        @(posedge clk);
        if (r) begin
            t = 0; m_active = 16'h0; m_full = 1'b0;
        end else begin
            acc = v && !m_full;
            if ((t % FRAME) == FRAME - 1 && m_full) begin
                m_active = m_pending;
                m_full   = 1'b0;
            end
            if (acc) begin
                m_pending = d;
                m_full    = 1'b1;
            end
            t++;
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
    endtask

    // Hold a load until the model says it was taken; bounded.
    task automatic load_held(input logic [15:0] d);
        bit taken;
        taken = 1'b0;
        for (int i = 0; i < 4 * FRAME && !taken; i++) begin
            taken = !m_full;
            step(1'b1, d, 1'b0);
        end
        if (!taken) check("load_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; bcd_data = 16'h0;
        t = 0; m_active = 16'h0; m_pending = 16'h0; m_full = 1'b0;
        repeat (3) @(posedge clk);

        // Idle scan after reset.
        idle(40);
        // Mid-frame load, then a second load offered while pending is full.
        idle(5);
        load_held(16'h1234);
        idle(3);
        load_held(16'h5678);
        load_held(16'h9ABF);
        idle(2 * FRAME);
        // Leading-zero value.
        load_held(16'h0007);
        idle(3 * FRAME);
        load_held(16'h0050);
        idle(2 * FRAME);
        // Reset during DRIVE of digit 2 with pending full.
        while (!((t % FRAME) == 2 * RD + DT + 1)) step(1'b0, 16'h0, 1'b0);
        load_held(16'hCAFE);
        while ((t / RD) % 4 != 2 || (t % RD) < DT) step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        idle(10);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = d & 16'h00FF;
            step(($urandom_range(0, 7) == 0), d, ($urandom_range(0, 299) == 0));
        end
        idle(FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
